// File: rtl/rf_text_font_loader.sv
// rf_text_font_loader: packs a glyph byte stream into byte-masked 32-bit writes to character RAM
module rf_text_font_loader (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [13:0] fontAddress_i,
  input  logic [5:0]  maxScanpix_i,
  input  logic [5:0]  maxscanline_i,
  input  logic [12:0] first_code_i,
  input  logic [12:0] num_chars_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        cs_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [11:0] adr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t state;
  logic [3:0]  sw, sw_in, col;
  logic [5:0]  msl, row;
  logic [9:0]  stride, stride_in, size_in;
  logic [12:0] nchr;
  logic [13:0] addr, gbase, gbase_in, code_off, nxt;
  logic        eog, last, last_r, empty;
  assign we_o = cs_o;
  always_comb begin
    sw_in = {1'b0, maxScanpix_i[5:3]} + {3'b0, |maxScanpix_i[2:0]};
    size_in = 10'(maxscanline_i) * 10'(sw_in);
    stride_in = {size_in[9:3] + 7'(|size_in[2:0]), 3'b000};
    code_off = 14'(first_code_i) * 14'(stride_in);
    gbase_in = (fontAddress_i & 14'h3ff8) + code_off;
    empty = sw_in == 4'd0 || maxscanline_i == 6'd0 || num_chars_i == 13'd0;
    eog = col == sw - 4'd1 && row == msl - 6'd1;
    last = eog && nchr == 13'd1;
    nxt = eog ? gbase + 14'(stride) : addr + 14'd1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cs_o <= 1'b0;
      sel_o <= 4'd0;
      adr_o <= 12'd0;
      dat_o <= 32'd0;
      byte_ready_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          busy_o <= 1'b1;
          sw <= sw_in;
          msl <= maxscanline_i;
          stride <= stride_in;
          nchr <= num_chars_i;
          addr <= gbase_in;
          gbase <= gbase_in;
          col <= 4'd0;
          row <= 6'd0;
          sel_o <= 4'd0;
          dat_o <= 32'd0;
          state <= empty ? DONE : LOAD;
          done_o <= empty;
          byte_ready_o <= !empty;
        end
        LOAD: if (byte_valid_i) begin
          sel_o[addr[1:0]] <= 1'b1;
          dat_o[{addr[1:0], 3'b000} +: 8] <= byte_i;
          adr_o <= addr[13:2];
          addr <= nxt;
          last_r <= last;
          col <= col == sw - 4'd1 ? 4'd0 : col + 4'd1;
          if (col == sw - 4'd1)
            row <= eog ? 6'd0 : row + 6'd1;
          if (eog) begin
            gbase <= nxt;
            nchr <= nchr - 13'd1;
          end
          // flush when the next byte would land in another word
          if (last || nxt[13:2] != addr[13:2]) begin
            state <= WRITE;
            byte_ready_o <= 1'b0;
            cs_o <= 1'b1;
          end
        end
        WRITE: if (ack_i) begin
          cs_o <= 1'b0;
          sel_o <= 4'd0;
          dat_o <= 32'd0;
          state <= last_r ? DONE : LOAD;
          done_o <= last_r;
          byte_ready_o <= !last_r;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rf_text_font_loader.sv
// tb_rf_text_font_loader: directed checks of glyph placement, packing, handshakes and reset
module tb_rf_text_font_loader;
  logic        clk_i = 0, rst_i = 1, start_i = 0, byte_valid_i = 0, ack_i = 0;
  logic [13:0] fontAddress_i = 0;
  logic [5:0]  maxScanpix_i = 0, maxscanline_i = 0;
  logic [12:0] first_code_i = 0, num_chars_i = 0;
  logic [7:0]  byte_i = 0;
  logic        byte_ready_o, cs_o, we_o, busy_o, done_o;
  logic [3:0]  sel_o;
  logic [11:0] adr_o;
  logic [31:0] dat_o;
  int n_chk = 0, n_err = 0, done_cnt = 0, cs_cycles = 0;
  bit rand_v = 0, rand_a = 0, hold_ack = 0, took = 0;
  logic [7:0]  src_q[$];
  logic [11:0] wr_adr[$], exp_adr[$];
  logic [3:0]  wr_sel[$], exp_sel[$];
  logic [31:0] wr_dat[$], exp_dat[$];

  rf_text_font_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .fontAddress_i(fontAddress_i),
    .maxScanpix_i(maxScanpix_i), .maxscanline_i(maxscanline_i), .first_code_i(first_code_i),
    .num_chars_i(num_chars_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .cs_o(cs_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o),
    .dat_o(dat_o), .ack_i(ack_i), .busy_o(busy_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (done_o) done_cnt++;
    if (cs_o) cs_cycles++;
  end

  // byte source: presents queue head, optionally with random gaps
  initial forever begin
    @(posedge clk_i);
    if (took && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    byte_valid_i = src_q.size() > 0 && (!rand_v || $urandom_range(0, 1) == 1);
    byte_i = src_q.size() > 0 ? src_q[0] : 8'h00;
    took = byte_valid_i && byte_ready_o;
  end

  // bus slave: optional ack delay, checks the cycle holds steady until acked
  initial forever begin
    logic [11:0] a0; logic [3:0] s0; logic [31:0] d0; int d;
    @(posedge clk_i); #1;
    if (ack_i) begin
      ack_i = 0;
      check("cs_after_ack", cs_o, 0);
    end else if (cs_o && !hold_ack) begin
      a0 = adr_o; s0 = sel_o; d0 = dat_o;
      check("we_eq_cs", we_o, 1);
      d = rand_a ? $urandom_range(0, 5) : 0;
      repeat (d) begin
        @(posedge clk_i); #1;
        check("hold_cs", cs_o, 1);
        check("hold_adr", adr_o, a0);
        check("hold_sel", sel_o, s0);
        check("hold_dat", dat_o, d0);
        check("hold_ready", byte_ready_o, 0);
      end
      wr_adr.push_back(adr_o); wr_sel.push_back(sel_o); wr_dat.push_back(dat_o);
      ack_i = 1;
    end
  end

  task automatic build_exp(input int base, input int sp, input int ln, input int code, input int n);
    int sw, st, a, k; logic [11:0] ca; logic [3:0] s; logic [31:0] d; bit open; logic [7:0] bv;
    exp_adr.delete(); exp_sel.delete(); exp_dat.delete(); src_q.delete();
    sw = sp / 8 + ((sp % 8 != 0) ? 1 : 0);
    st = ((ln * sw + 7) / 8) * 8;
    k = 0; open = 0; s = 0; d = 0; ca = 0;
    for (int c = 0; c < n; c++)
      for (int r = 0; r < ln; r++)
        for (int b = 0; b < sw; b++) begin
          a = ((base & 'h3ff8) + (code + c) * st + r * sw + b) & 'h3fff;
          if (open && 12'(a >> 2) != ca) begin
            exp_adr.push_back(ca); exp_sel.push_back(s); exp_dat.push_back(d);
            s = 0; d = 0;
          end
          open = 1; ca = 12'(a >> 2);
          bv = 8'(170 + 17 * k);
          s[a % 4] = 1'b1;
          d[(a % 4) * 8 +: 8] = bv;
          src_q.push_back(bv);
          k++;
        end
    if (open) begin
      exp_adr.push_back(ca); exp_sel.push_back(s); exp_dat.push_back(d);
    end
  endtask

  task automatic pulse_start(input int base, input int sp, input int ln, input int code, input int n);
    wr_adr.delete(); wr_sel.delete(); wr_dat.delete();
    done_cnt = 0; cs_cycles = 0;
    build_exp(base, sp, ln, code, n);
    fontAddress_i = 14'(base); maxScanpix_i = 6'(sp); maxscanline_i = 6'(ln);
    first_code_i = 13'(code); num_chars_i = 13'(n);
    start_i = 1;
    @(posedge clk_i); #1;
    start_i = 0;
    fontAddress_i = 0; maxScanpix_i = 0; maxscanline_i = 0; first_code_i = 0; num_chars_i = 0;
  endtask

  task automatic run(input string nm, input int base, input int sp, input int ln, input int code,
                     input int n, input bit rv, input bit ra);
    bit empty;
    rand_v = rv; rand_a = ra;
    empty = (sp == 0) || (ln == 0) || (n == 0);
    pulse_start(base, sp, ln, code, n);
    check({nm, "_busy"}, busy_o, 1);
    if (empty) check({nm, "_done_direct"}, done_o, 1);
    else check({nm, "_ready_n1"}, byte_ready_o, 1);
    for (int i = 0; i < 4000 && !done_o; i++) begin
      @(posedge clk_i); #1;
    end
    check({nm, "_done_seen"}, done_o, 1);
    @(posedge clk_i); #1;
    check({nm, "_done_pulse"}, done_o, 0);
    check({nm, "_idle_busy"}, busy_o, 0);
    check({nm, "_done_cnt"}, done_cnt, 1);
    check({nm, "_nwrites"}, wr_adr.size(), exp_adr.size());
    for (int i = 0; i < exp_adr.size() && i < wr_adr.size(); i++) begin
      check({nm, "_adr"}, wr_adr[i], exp_adr[i]);
      check({nm, "_sel"}, wr_sel[i], exp_sel[i]);
      check({nm, "_dat"}, wr_dat[i], exp_dat[i]);
    end
  endtask

  initial begin
    logic [11:0] t2_adr[6] = '{12'h000, 12'h001, 12'h002, 12'h004, 12'h005, 12'h006};
    logic [3:0]  t2_sel[6] = '{4'hf, 4'hf, 4'h1, 4'hf, 4'hf, 4'h1};
    logic [11:0] t6_adr[4] = '{12'hffe, 12'hfff, 12'h000, 12'h001};
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cs", cs_o, 0); check("rst_we", we_o, 0); check("rst_sel", sel_o, 0);
    check("rst_adr", adr_o, 0); check("rst_dat", dat_o, 0); check("rst_ready", byte_ready_o, 0);
    check("rst_busy", busy_o, 0); check("rst_done", done_o, 0);
    rst_i = 0;
    @(posedge clk_i); #1;

    run("f12x18", 'h0100, 12, 18, 'h41, 1, 0, 0);
    check("f12_n", wr_adr.size(), 9);
    check("f12_adr0", wr_adr[0], 12'h2ca);
    check("f12_sel0", wr_sel[0], 4'hf);
    check("f12_dat0", wr_dat[0], 32'hddccbbaa);
    check("f12_adr8", wr_adr[8], 12'h2d2);

    run("sw3", 0, 20, 3, 0, 2, 0, 0);
    for (int i = 0; i < 6; i++) begin
      check("sw3_adr_hand", wr_adr[i], t2_adr[i]);
      check("sw3_sel_hand", wr_sel[i], t2_sel[i]);
    end

    run("rand", 'h0100, 12, 18, 'h41, 2, 1, 1);
    run("sw3_rand", 0, 20, 3, 0, 2, 1, 1);

    run("nchr0", 'h0100, 12, 18, 5, 0, 0, 0);
    check("nchr0_cs", cs_cycles, 0);
    run("lines0", 'h0100, 12, 0, 5, 3, 0, 0);
    check("lines0_cs", cs_cycles, 0);

    hold_ack = 1;
    rand_v = 0;
    pulse_start('h0100, 12, 18, 'h41, 1);
    for (int i = 0; i < 100 && !cs_o; i++) begin
      @(posedge clk_i); #1;
    end
    check("hold_cs_seen", cs_o, 1);
    rst_i = 1;
    @(posedge clk_i); #1;
    rst_i = 0;
    src_q.delete();
    check("mid_cs", cs_o, 0); check("mid_we", we_o, 0); check("mid_sel", sel_o, 0);
    check("mid_adr", adr_o, 0); check("mid_dat", dat_o, 0); check("mid_ready", byte_ready_o, 0);
    check("mid_busy", busy_o, 0); check("mid_done", done_o, 0);
    hold_ack = 0;
    @(posedge clk_i); #1;
    run("after_rst", 0, 20, 3, 0, 2, 0, 0);

    run("wrap", 'h3ff8, 8, 8, 0, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("wrap_adr_hand", wr_adr[i], t6_adr[i]);
      check("wrap_sel_hand", wr_sel[i], 4'hf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
